// File: rtl/coin_collector_pkg.sv
// Shared constants for the coin collector: start positions, respawn rows, LFSR taps, FSM encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package coin_pkg;

  localparam int MAX_COINS = 16;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } coin_xy_t;

  // Power-on coin placement; slots beyond N_COINS are simply not used.
  localparam coin_xy_t INIT_XY [MAX_COINS] = '{
    '{x: 10'd40,  y: 10'd100}, '{x: 10'd120, y: 10'd100},
    '{x: 10'd200, y: 10'd200}, '{x: 10'd224, y: 10'd200},
    '{x: 10'd320, y: 10'd300}, '{x: 10'd400, y: 10'd300},
    '{x: 10'd480, y: 10'd360}, '{x: 10'd560, y: 10'd360},
    '{x: 10'd40,  y: 10'd420}, '{x: 10'd104, y: 10'd420},
    '{x: 10'd168, y: 10'd420}, '{x: 10'd232, y: 10'd420},
    '{x: 10'd296, y: 10'd420}, '{x: 10'd360, y: 10'd420},
    '{x: 10'd424, y: 10'd420}, '{x: 10'd488, y: 10'd420}
  };

  // Platform rows a respawned coin may land on.
  localparam logic [9:0] ROW_Y [8] = '{
    10'd64, 10'd96, 10'd128, 10'd160, 10'd200, 10'd240, 10'd300, 10'd360
  };

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Keep respawn x on screen: fold the top of the 10-bit range back by 512.
  function automatic logic [9:0] respawn_x(input logic [9:0] r);
    return (r > 10'd624) ? (r - 10'd512) : r;
  endfunction

  // Three-digit BCD increment that sticks at 999.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] s);
    logic [3:0] d0, d1, d2;
    d0 = s[3:0];
    d1 = s[7:4];
    d2 = s[11:8];
    if (s == 12'h999) return s;
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

endpackage

// File: rtl/coin_collector_if.sv
// Bundle between the sprite/pixel pipeline and the coin collector.
// Latency: pixel outputs are combinational on xg/yg; score/pulse follow the slot scan.
// Backpressure: none; frame_tick is a fire-and-forget pulse.
interface coin_collector_if;
  logic       frame_tick;
  logic [9:0] mario_left;
  logic [9:0] mario_top;
  logic [9:0] xg;
  logic [9:0] yg;
  logic       coin_on;
  logic [3:0] coin_x_rom;
  logic [3:0] coin_y_rom;
  logic [11:0] score_bcd;
  logic       collect_pulse;

  modport master (
    output frame_tick, mario_left, mario_top, xg, yg,
    input  coin_on, coin_x_rom, coin_y_rom, score_bcd, collect_pulse
  );

  modport slave (
    input  frame_tick, mario_left, mario_top, xg, yg,
    output coin_on, coin_x_rom, coin_y_rom, score_bcd, collect_pulse
  );
endinterface

// File: rtl/coin_collector_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick coin respawn positions.
// Latency: value reflects a step on the cycle after step is high.
// Backpressure: advances only when step is asserted, otherwise holds.
module lfsr16
  import coin_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  // Shift in the XOR of the tapped bits when a respawn consumes a value.
  always_comb begin
    value_d = value_q;
    if (step) value_d = {value_q[14:0], ^(value_q & LFSR_TAPS)};
  end

  // State register; reset reloads the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= seed;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/coin_collector.sv
// Coin slot array: per-frame scan collects coins under Mario, keeps BCD score, respawns coins.
// Latency: scan runs one slot per cycle on cycles 1..N_COINS after frame_tick; pixel path is combinational.
// Backpressure: none; a frame_tick arriving mid-scan is dropped.
module coin_collector
  import coin_pkg::*;
#(
  parameter int          N_COINS        = 8,
  parameter int          COIN_SIZE      = 15,
  parameter int          MARIO_W        = 27,
  parameter int          MARIO_H        = 31,
  parameter int          RESPAWN_FRAMES = 120,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  coin_collector_if.slave bus
);

  localparam int IW = $clog2(N_COINS);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [9:0]           ml_q, ml_d, mt_q, mt_d;
  logic [N_COINS-1:0]   valid_q, valid_d;
  logic [9:0]           cx_q [N_COINS];
  logic [9:0]           cx_d [N_COINS];
  logic [9:0]           cy_q [N_COINS];
  logic [9:0]           cy_d [N_COINS];
  logic [7:0]           resp_q [N_COINS];
  logic [7:0]           resp_d [N_COINS];
  logic [11:0]          score_q, score_d;

  logic        collect;
  logic        lfsr_step;
  logic [15:0] lfsr_val;
  logic        unused_lfsr_hi;
  logic [9:0]  cur_cx, cur_cy;
  logic        overlap;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // The top LFSR bits only matter for the feedback, not for the position.
  assign unused_lfsr_hi = ^lfsr_val[15:13];

  assign cur_cx = cx_q[idx_q];
  assign cur_cy = cy_q[idx_q];

  // 11-bit compares so box edges near 1023 never wrap; all edges inclusive.
  assign overlap = ({1'b0, ml_q} <= ({1'b0, cur_cx} + 11'(COIN_SIZE))) &&
                   ({1'b0, cur_cx} <= ({1'b0, ml_q} + 11'(MARIO_W))) &&
                   ({1'b0, mt_q} <= ({1'b0, cur_cy} + 11'(COIN_SIZE))) &&
                   ({1'b0, cur_cy} <= ({1'b0, mt_q} + 11'(MARIO_H)));

  // Scan FSM next state: snapshot Mario on frame_tick, then visit one slot per cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ml_d      = ml_q;
    mt_d      = mt_q;
    valid_d   = valid_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    resp_d    = resp_q;
    score_d   = score_q;
    collect   = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          ml_d    = bus.mario_left;
          mt_d    = bus.mario_top;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_q[idx_q]) begin
          if (overlap) begin
            valid_d[idx_q] = 1'b0;
            resp_d[idx_q]  = 8'(RESPAWN_FRAMES);
            collect        = 1'b1;
            score_d        = bcd_inc_sat(score_q);
          end
        end else begin
          // A slot revived here is not overlap-tested until the next frame.
          if (resp_q[idx_q] != 8'd0) resp_d[idx_q] = resp_q[idx_q] - 8'd1;
          if (resp_q[idx_q] == 8'd1) begin
            valid_d[idx_q] = 1'b1;
            cx_d[idx_q]    = respawn_x(lfsr_val[9:0]);
            cy_d[idx_q]    = ROW_Y[lfsr_val[12:10]];
            lfsr_step      = 1'b1;
          end
        end
        if (idx_q == IW'(N_COINS - 1)) state_d = IDLE;
        else                           idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // All scan state in one register bank; reset restores the power-on coin layout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ml_q    <= '0;
      mt_q    <= '0;
      valid_q <= '1;
      score_q <= '0;
      for (int i = 0; i < N_COINS; i++) begin
        cx_q[i]   <= INIT_XY[i].x;
        cy_q[i]   <= INIT_XY[i].y;
        resp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ml_q    <= ml_d;
      mt_q    <= mt_d;
      valid_q <= valid_d;
      score_q <= score_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      resp_q  <= resp_d;
    end
  end

  // Pixel hit test; ROM offsets come from the lowest-index slot covering the pixel.
  always_comb begin
    logic [9:0] dx, dy;
    bus.coin_on    = 1'b0;
    bus.coin_x_rom = 4'd0;
    bus.coin_y_rom = 4'd0;
    for (int i = 0; i < N_COINS; i++) begin
      dx = bus.xg - cx_q[i];
      dy = bus.yg - cy_q[i];
      if (valid_q[i] &&
          ({1'b0, bus.xg} >= {1'b0, cx_q[i]}) &&
          ({1'b0, bus.xg} <= ({1'b0, cx_q[i]} + 11'(COIN_SIZE))) &&
          ({1'b0, bus.yg} >= {1'b0, cy_q[i]}) &&
          ({1'b0, bus.yg} <= ({1'b0, cy_q[i]} + 11'(COIN_SIZE)))) begin
        if (!bus.coin_on) begin
          bus.coin_x_rom = dx[3:0];
          bus.coin_y_rom = dy[3:0];
        end
        bus.coin_on = 1'b1;
      end
    end
  end

  // Pulse is decoded from registered scan state so it lines up with the slot being processed.
  assign bus.collect_pulse = collect;
  assign bus.score_bcd     = score_q;

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector: pixel vectors, collect/boundary frames, respawn, BCD saturation, reset.
// Latency: one frame = tick cycle + 8 scan cycles + 1 idle cycle.
// Backpressure: n/a.
module tb_coin_collector;

  localparam logic [15:0] SEED = 16'h05F0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  coin_collector_if bus();

  coin_collector #(.LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] tb_x   [8] = '{10'd40, 10'd120, 10'd200, 10'd224, 10'd320, 10'd400, 10'd480, 10'd560};
  logic [9:0] tb_y   [8] = '{10'd100, 10'd100, 10'd200, 10'd200, 10'd300, 10'd300, 10'd360, 10'd360};
  logic [9:0] tb_row [8] = '{10'd64, 10'd96, 10'd128, 10'd160, 10'd200, 10'd240, 10'd300, 10'd360};

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic [3:0] xr;
    logic [3:0] yr;
  } pix_vec_t;

  pix_vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic on, input logic [3:0] xr, input logic [3:0] yr);
    bus.xg = x;
    bus.yg = y;
    #1;
    check({name, "_on"}, 32'(bus.coin_on), 32'(on));
    check({name, "_xr"}, 32'(bus.coin_x_rom), 32'(xr));
    check({name, "_yr"}, 32'(bus.coin_y_rom), 32'(yr));
  endtask

  // Reference pixel model for the power-on layout (all slots valid).
  task automatic model_pix(input int x, input int y, output logic on, output logic [3:0] xr,
                           output logic [3:0] yr);
    on = 1'b0; xr = 4'd0; yr = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!on && x >= int'(tb_x[i]) && x <= int'(tb_x[i]) + 15 &&
          y >= int'(tb_y[i]) && y <= int'(tb_y[i]) + 15) begin
        on = 1'b1;
        xr = 4'(x - int'(tb_x[i]));
        yr = 4'(y - int'(tb_y[i]));
      end
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [9:0] pred_x(input logic [15:0] s);
    return (s[9:0] > 10'd624) ? s[9:0] - 10'd512 : s[9:0];
  endfunction

  // One frame: mask bit k-1 = collect_pulse in scan cycle k; bit 8 is the idle cycle after.
  task automatic run_frame(input logic [9:0] ml, input logic [9:0] mt, input bit mid_tick,
                           input logic [9:0] ml2, input logic [9:0] mt2, output logic [8:0] mask);
    mask = '0;
    @(negedge clk);
    bus.mario_left = ml;
    bus.mario_top  = mt;
    bus.frame_tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.frame_tick = 1'b0;
      mask[k-1] = bus.collect_pulse;
      if (mid_tick && k == 2) begin
        bus.frame_tick = 1'b1;
        bus.mario_left = ml2;
        bus.mario_top  = mt2;
      end
      if (mid_tick && k == 3) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic frame_chk(input string name, input logic [9:0] ml, input logic [9:0] mt,
                           input logic [8:0] exp_mask, input logic [11:0] exp_score);
    logic [8:0] m;
    run_frame(ml, mt, 1'b0, 10'd0, 10'd0, m);
    check({name, "_pulses"}, 32'(m), 32'(exp_mask));
    check({name, "_score"}, 32'(bus.score_bcd), 32'(exp_score));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [8:0]  m, acc;
    logic        e_on;
    logic [3:0]  e_xr, e_yr;
    int          errs;
    logic [15:0] s2, s3;
    logic [9:0]  p2x, p2y, p3x, p3y;

    vecs[0]  = '{10'd40,  10'd100, 1'b1, 4'h0, 4'h0};
    vecs[1]  = '{10'd55,  10'd115, 1'b1, 4'hF, 4'hF};
    vecs[2]  = '{10'd56,  10'd100, 1'b0, 4'h0, 4'h0};
    vecs[3]  = '{10'd39,  10'd100, 1'b0, 4'h0, 4'h0};
    vecs[4]  = '{10'd40,  10'd116, 1'b0, 4'h0, 4'h0};
    vecs[5]  = '{10'd40,  10'd99,  1'b0, 4'h0, 4'h0};
    vecs[6]  = '{10'd215, 10'd205, 1'b1, 4'hF, 4'h5};
    vecs[7]  = '{10'd216, 10'd205, 1'b0, 4'h0, 4'h0};
    vecs[8]  = '{10'd224, 10'd200, 1'b1, 4'h0, 4'h0};
    vecs[9]  = '{10'd239, 10'd215, 1'b1, 4'hF, 4'hF};
    vecs[10] = '{10'd570, 10'd370, 1'b1, 4'hA, 4'hA};
    vecs[11] = '{10'd0,   10'd0,   1'b0, 4'h0, 4'h0};
    vecs[12] = '{10'd487, 10'd363, 1'b1, 4'h7, 4'h3};

    bus.frame_tick = 1'b0;
    bus.mario_left = 10'd1000;
    bus.mario_top  = 10'd1000;
    bus.xg         = 10'd0;
    bus.yg         = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_score", 32'(bus.score_bcd), 32'h000);
    check("rst_pulse", 32'(bus.collect_pulse), 32'd0);
    for (int v = 0; v < 13; v++)
      probe($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].on, vecs[v].xr, vecs[v].yr);

    // Window around each start box against the reference model
    for (int c = 0; c < 8; c++) begin
      errs = 0;
      for (int dy = -2; dy <= 17; dy++) begin
        for (int dx = -2; dx <= 17; dx++) begin
          bus.xg = 10'(int'(tb_x[c]) + dx);
          bus.yg = 10'(int'(tb_y[c]) + dy);
          #1;
          model_pix(int'(tb_x[c]) + dx, int'(tb_y[c]) + dy, e_on, e_xr, e_yr);
          if (bus.coin_on !== e_on || bus.coin_x_rom !== e_xr || bus.coin_y_rom !== e_yr) errs++;
        end
      end
      check($sformatf("window_coin%0d_errs", c), 32'(errs), 32'd0);
    end

    // Collect coin 0, then x/y boundary pairs on coins 1, 4, 5
    frame_chk("coin0", 10'd40, 10'd100, 9'h001, 12'h001);
    probe("coin0_gone", 10'd40, 10'd100, 1'b0, 4'h0, 4'h0);
    probe("coin1_still", 10'd120, 10'd100, 1'b1, 4'h0, 4'h0);
    frame_chk("x_edge_out", 10'd136, 10'd100, 9'h000, 12'h001);
    frame_chk("x_edge_in",  10'd135, 10'd100, 9'h002, 12'h002);
    frame_chk("y_edge_out", 10'd320, 10'd316, 9'h000, 12'h002);
    frame_chk("y_edge_in",  10'd320, 10'd315, 9'h010, 12'h003);
    frame_chk("w_edge_out", 10'd372, 10'd300, 9'h000, 12'h003);
    frame_chk("w_edge_in",  10'd373, 10'd300, 9'h020, 12'h004);
    frame_chk("coins23",    10'd200, 10'd200, 9'h00C, 12'h006);

    // A tick during the scan must not re-snapshot Mario or restart the scan
    run_frame(10'd480, 10'd360, 1'b1, 10'd560, 10'd360, m);
    check("midtick_pulses", 32'(m), 32'h040);
    check("midtick_score", 32'(bus.score_bcd), 32'h007);
    probe("coin7_kept", 10'd560, 10'd360, 1'b1, 4'h0, 4'h0);

    // Respawn: fresh LFSR, collect 2 and 3 together, wait out the delay
    do_reset();
    frame_chk("resp_collect", 10'd200, 10'd200, 9'h00C, 12'h002);
    s2  = SEED;
    s3  = lfsr_next(s2);
    p2x = pred_x(s2); p2y = tb_row[s2[12:10]];
    p3x = pred_x(s3); p3y = tb_row[s3[12:10]];
    acc = '0;
    for (int t = 0; t < 119; t++) begin
      run_frame(10'd1000, 10'd1000, 1'b0, 10'd0, 10'd0, m);
      acc |= m;
    end
    check("resp_wait_pulses", 32'(acc), 32'd0);
    probe("resp_119_c2", p2x, p2y, 1'b0, 4'h0, 4'h0);
    probe("resp_119_c3", p3x, p3y, 1'b0, 4'h0, 4'h0);
    probe("resp_119_old", 10'd200, 10'd200, 1'b0, 4'h0, 4'h0);
    frame_chk("resp_120", 10'd1000, 10'd1000, 9'h000, 12'h002);
    probe("resp_c2_tl", p2x, p2y, 1'b1, 4'h0, 4'h0);
    probe("resp_c2_br", p2x + 10'd15, p2y + 10'd15, 1'b1, 4'hF, 4'hF);
    probe("resp_c3_tl", p3x, p3y, 1'b1, 4'h0, 4'h0);
    probe("resp_old_gone", 10'd200, 10'd200, 1'b0, 4'h0, 4'h0);

    // BCD carry and saturation
    @(negedge clk);
    force dut.score_q = 12'h099;
    @(negedge clk);
    release dut.score_q;
    @(negedge clk);
    check("force_099", 32'(bus.score_bcd), 32'h099);
    frame_chk("carry_100", 10'd40, 10'd100, 9'h001, 12'h100);
    @(negedge clk);
    force dut.score_q = 12'h998;
    @(negedge clk);
    release dut.score_q;
    @(negedge clk);
    frame_chk("to_999", 10'd120, 10'd100, 9'h002, 12'h999);
    frame_chk("sat_999", 10'd320, 10'd300, 9'h010, 12'h999);

    // Reset in the middle of a scan
    @(negedge clk);
    bus.mario_left = 10'd400;
    bus.mario_top  = 10'd300;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midscan_rst_score", 32'(bus.score_bcd), 32'h000);
    check("midscan_rst_pulse", 32'(bus.collect_pulse), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++)
      probe($sformatf("post_rst_coin%0d", c), tb_x[c], tb_y[c], 1'b1, 4'h0, 4'h0);
    frame_chk("post_rst_idle", 10'd1000, 10'd1000, 9'h000, 12'h000);
    frame_chk("post_rst_coin5", 10'd400, 10'd300, 9'h020, 12'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
